// File: rtl/lcd_init_seq_if.sv
// Byte stream with valid/ready handshake and a D/C flag, shared by the
// SPI writer port and the pixel-source port of the init sequencer.
interface lcd_init_seq_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       dc;

  modport master (output valid, output data, output dc, input ready);
  modport slave  (input valid, input data, input dc, output ready);
endinterface

// File: rtl/lcd_init_seq.sv
// LCD power-up sequencer: panel reset pulse, walk of the init-command ROM
// (bytes and delays), then hands the SPI byte writer to the pixel source.
module lcd_init_seq #(
  parameter logic [23:0] DELAY_255ms = 24'd12_750_000,
  parameter logic [15:0] DELAY_UNIT  = 16'd50_000,
  parameter int          ROM_AW      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reinit,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  lcd_init_seq_if.master    wr,
  lcd_init_seq_if.slave     pix,
  output logic              lcd_reset,
  output logic              lcd_blk,
  output logic              init_done
);

  localparam logic [2:0] RST_LOW  = 3'd0;
  localparam logic [2:0] RST_HIGH = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] DECODE   = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;
  localparam logic [2:0] DELAY    = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [1:0] TYPE_CMD   = 2'b00;
  localparam logic [1:0] TYPE_DATA  = 2'b01;
  localparam logic [1:0] TYPE_DELAY = 2'b10;

  logic [2:0]        state_reg, state_next;
  logic [23:0]       rst_cnt_reg, rst_cnt_next;
  logic [15:0]       unit_cnt_reg, unit_cnt_next;
  logic [7:0]        rep_cnt_reg, rep_cnt_next;
  logic [ROM_AW-1:0] rom_addr_reg, rom_addr_next;
  logic              wr_valid_reg, wr_valid_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic              wr_dc_reg, wr_dc_next;
  logic              lcd_reset_reg, lcd_reset_next;
  logic              lcd_blk_reg, lcd_blk_next;
  logic              init_done_reg, init_done_next;

  logic              in_done;
  logic              last_entry;
  logic              rst_wait_over;
  logic              unit_over;
  logic [1:0]        entry_type;
  logic [7:0]        payload;
  logic [2:0]        advance_state;
  logic [ROM_AW-1:0] advance_addr;

  assign in_done       = (state_reg == DONE);
  assign last_entry    = (rom_addr_reg == {ROM_AW{1'b1}});
  assign rst_wait_over = (rst_cnt_reg == DELAY_255ms - 24'd1);
  assign unit_over     = (unit_cnt_reg == DELAY_UNIT - 16'd1);
  assign entry_type    = rom_data[9:8];
  assign payload       = rom_data[7:0];

  // The last ROM slot finishes the program rather than wrapping to address 0.
  assign advance_state = last_entry ? DONE : FETCH;
  assign advance_addr  = last_entry ? rom_addr_reg : rom_addr_reg + ROM_AW'(1);

  always_comb begin
    state_next     = state_reg;
    rst_cnt_next   = rst_cnt_reg;
    unit_cnt_next  = unit_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    rom_addr_next  = rom_addr_reg;
    wr_valid_next  = wr_valid_reg;
    wr_data_next   = wr_data_reg;
    wr_dc_next     = wr_dc_reg;
    lcd_reset_next = lcd_reset_reg;
    lcd_blk_next   = lcd_blk_reg;
    init_done_next = init_done_reg;

    case (state_reg)
      RST_LOW: begin
        lcd_reset_next = 1'b0;
        if (rst_wait_over) begin
          rst_cnt_next   = '0;
          lcd_reset_next = 1'b1;
          state_next     = RST_HIGH;
        end else begin
          rst_cnt_next = rst_cnt_reg + 24'd1;
        end
      end

      RST_HIGH: begin
        if (rst_wait_over) begin
          rst_cnt_next  = '0;
          rom_addr_next = '0;
          state_next    = FETCH;
        end else begin
          rst_cnt_next = rst_cnt_reg + 24'd1;
        end
      end

      FETCH: begin
        state_next = DECODE;
      end

      DECODE: begin
        case (entry_type)
          TYPE_CMD, TYPE_DATA: begin
            wr_valid_next = 1'b1;
            wr_data_next  = payload;
            wr_dc_next    = (entry_type == TYPE_DATA);
            state_next    = SEND;
          end
          TYPE_DELAY: begin
            if (payload == 8'd0) begin
              rom_addr_next = advance_addr;
              state_next    = advance_state;
            end else begin
              rep_cnt_next  = payload;
              unit_cnt_next = '0;
              state_next    = DELAY;
            end
          end
          default: begin
            state_next = DONE;
          end
        endcase
      end

      SEND: begin
        if (wr.ready) begin
          wr_valid_next = 1'b0;
          rom_addr_next = advance_addr;
          state_next    = advance_state;
        end
      end

      // Inner counter spans one unit, outer counter counts remaining units.
      DELAY: begin
        if (unit_over) begin
          unit_cnt_next = '0;
          if (rep_cnt_reg == 8'd1) begin
            rep_cnt_next  = '0;
            rom_addr_next = advance_addr;
            state_next    = advance_state;
          end else begin
            rep_cnt_next = rep_cnt_reg - 8'd1;
          end
        end else begin
          unit_cnt_next = unit_cnt_reg + 16'd1;
        end
      end

      DONE: begin
        if (reinit) begin
          state_next     = RST_LOW;
          rst_cnt_next   = '0;
          rom_addr_next  = '0;
          lcd_reset_next = 1'b0;
          lcd_blk_next   = 1'b0;
          init_done_next = 1'b0;
        end else begin
          lcd_blk_next   = 1'b1;
          init_done_next = 1'b1;
        end
      end

      default: begin
        state_next = RST_LOW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RST_LOW;
      rst_cnt_reg   <= '0;
      unit_cnt_reg  <= '0;
      rep_cnt_reg   <= '0;
      rom_addr_reg  <= '0;
      wr_valid_reg  <= 1'b0;
      wr_data_reg   <= '0;
      wr_dc_reg     <= 1'b0;
      lcd_reset_reg <= 1'b0;
      lcd_blk_reg   <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rst_cnt_reg   <= rst_cnt_next;
      unit_cnt_reg  <= unit_cnt_next;
      rep_cnt_reg   <= rep_cnt_next;
      rom_addr_reg  <= rom_addr_next;
      wr_valid_reg  <= wr_valid_next;
      wr_data_reg   <= wr_data_next;
      wr_dc_reg     <= wr_dc_next;
      lcd_reset_reg <= lcd_reset_next;
      lcd_blk_reg   <= lcd_blk_next;
      init_done_reg <= init_done_next;
    end
  end

  // Once initialised the writer belongs to the pixel source, combinationally.
  assign wr.valid  = in_done ? pix.valid : wr_valid_reg;
  assign wr.data   = in_done ? pix.data  : wr_data_reg;
  assign wr.dc     = in_done ? pix.dc    : wr_dc_reg;
  assign pix.ready = in_done ? wr.ready  : 1'b0;

  assign rom_addr  = rom_addr_reg;
  assign lcd_reset = lcd_reset_reg;
  assign lcd_blk   = lcd_blk_reg;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Randomised bench for lcd_init_seq: ROM programs are replayed through a
// timing/byte reference model, plus pass-through, reinit and reset cases.
module tb_lcd_init_seq;
  localparam int D = 20;
  localparam int U = 4;

  logic       clk;
  logic       rst_n;
  logic       reinit;
  logic [5:0] rom_addr;
  logic [9:0] rom_data;
  logic       lcd_reset;
  logic       lcd_blk;
  logic       init_done;

  lcd_init_seq_if wr_bus ();
  lcd_init_seq_if pix_bus ();

  lcd_init_seq #(
    .DELAY_255ms(24'd20),
    .DELAY_UNIT (16'd4),
    .ROM_AW     (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reinit   (reinit),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .wr       (wr_bus),
    .pix      (pix_bus),
    .lcd_reset(lcd_reset),
    .lcd_blk  (lcd_blk),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] rom_mem [64];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         rel;
  } acc_t;

  acc_t acc_q[$];
  int   rise_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_lcd_reset"}, lcd_reset, 0);
    check({tag, "_lcd_blk"}, lcd_blk, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_wr_valid"}, wr_bus.valid, 0);
    check({tag, "_wr_data"}, wr_bus.data, 0);
    check({tag, "_wr_dc"}, wr_bus.dc, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_pix_ready"}, pix_bus.ready, 0);
  endtask

  task automatic set_directed();
    for (int a = 0; a < 64; a++) rom_mem[a] = 10'h3FF;
    rom_mem[0] = {2'b00, 8'h11};
    rom_mem[1] = {2'b10, 8'd2};
    rom_mem[2] = {2'b00, 8'h29};
    rom_mem[3] = {2'b01, 8'h55};
    rom_mem[4] = {2'b11, 8'h00};
  endtask

  task automatic gen_rom(input bit with_end);
    int r;
    int end_at;
    end_at = with_end ? int'($urandom_range(4, 24)) : 64;
    for (int a = 0; a < 64; a++) begin
      r = int'($urandom_range(0, 9));
      if (a == end_at)  rom_mem[a] = {2'b11, 8'($urandom)};
      else if (r < 4)   rom_mem[a] = {2'b00, 8'($urandom)};
      else if (r < 7)   rom_mem[a] = {2'b01, 8'($urandom)};
      else              rom_mem[a] = {2'b10, 8'($urandom_range(0, 3))};
    end
  endtask

  task automatic do_reset(output int b);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
  endtask

  // mode 0: always ready, 1: random ready, 2: five stall cycles on byte 0x29
  task automatic run_init(input int base_c, input int mode, input int reinit_at);
    int         rel;
    int         done_rel;
    int         hold29;
    int         stall_left;
    int         t;
    int         k;
    int         done_exp;
    bit         done;
    bit         acc_seen;
    logic [5:0] acc_addr;
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic       pdc;
    logic [9:0] e;
    acc_q.delete();
    rise_q.delete();
    pv = 0; pr = 0; pd = 0; pdc = 0;
    hold29 = 0; stall_left = 5; done = 0; acc_seen = 0; acc_addr = 0; done_rel = -1;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(posedge clk);
      #1;
      rel = cyc - base_c;
      reinit = (rel == reinit_at);
      case (mode)
        0: wr_bus.ready = 1'b1;
        1: wr_bus.ready = 1'($urandom_range(0, 1));
        default: begin
          if (wr_bus.valid && wr_bus.data == 8'h29 && stall_left > 0) begin
            wr_bus.ready = 1'b0;
            stall_left--;
          end else begin
            wr_bus.ready = 1'b1;
          end
        end
      endcase
      pix_bus.valid = (rel < 2 * D) ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_bus.data  = 8'($urandom);
      pix_bus.dc    = 1'($urandom);
      @(negedge clk);
      check("lcd_reset_phase", lcd_reset, rel >= D);
      check("blk_tracks_done", lcd_blk, init_done);
      if (rel <= 2 * D + 1) begin
        check("addr_before_walk", rom_addr, 0);
        check("valid_before_walk", wr_bus.valid, 0);
      end
      if (rel < 2 * D || wr_bus.valid) check("pix_ready_blocked", pix_bus.ready, 0);
      if (acc_seen && acc_addr != 6'h3F) check("addr_inc", rom_addr, acc_addr + 6'd1);
      acc_seen = 0;
      if (pv && !pr) begin
        check("hold_valid", wr_bus.valid, 1);
        check("hold_data", wr_bus.data, pd);
        check("hold_dc", wr_bus.dc, pdc);
      end
      if (wr_bus.valid && !pv) rise_q.push_back(rel);
      if (wr_bus.valid && wr_bus.ready) begin
        acc_q.push_back('{wr_bus.data, wr_bus.dc, rel});
        acc_seen = 1;
        acc_addr = rom_addr;
      end
      if (mode == 2 && wr_bus.valid && wr_bus.data == 8'h29) hold29++;
      pv = wr_bus.valid; pr = wr_bus.ready; pd = wr_bus.data; pdc = wr_bus.dc;
      if (init_done) begin
        done = 1;
        done_rel = rel;
      end
    end
    reinit = 1'b0;
    if (!done) check("init_timeout", 0, 1);
    if (mode == 2) check("stall_valid_cycles", hold29, 6);

    // Reference walk: every entry costs fetch+decode, bytes wait for accept.
    t = 2 * D;
    k = 0;
    done_exp = -1;
    for (int a = 0; a < 64; a++) begin
      e = rom_mem[a];
      if (e[9:8] == 2'b11) begin
        done_exp = t + 3;
        break;
      end
      if (e[9:8] == 2'b10) begin
        t = t + 2 + int'(e[7:0]) * U;
      end else begin
        if (k < rise_q.size()) check("valid_rise_cycle", rise_q[k], t + 2);
        if (k < acc_q.size()) begin
          check("byte_data", acc_q[k].data, e[7:0]);
          check("byte_dc", acc_q[k].dc, e[8]);
          t = acc_q[k].rel + 1;
        end else begin
          t = t + 3;
        end
        k++;
      end
      if (a == 63) done_exp = t + 1;
    end
    check("byte_count", acc_q.size(), k);
    check("rise_count", rise_q.size(), k);
    check("done_cycle", done_rel, done_exp);
  endtask

  int base;
  int c;
  int cnt;
  bit found;

  initial begin
    rst_n = 1'b0;
    reinit = 1'b0;
    wr_bus.ready = 1'b0;
    pix_bus.valid = 1'b0;
    pix_bus.data = 8'h00;
    pix_bus.dc = 1'b0;
    set_directed();
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    base = cyc;

    // Directed program with a reinit pulse during RST_HIGH that must be ignored
    run_init(base, 0, 30);
    if (acc_q.size() >= 2) check("gap_11_to_29", (acc_q[1].rel - acc_q[0].rel) >= 11, 1);
    else check("gap_11_to_29", acc_q.size(), 2);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      pix_bus.valid = (i < 8) ? 1'b1 : 1'($urandom);
      pix_bus.data  = (i < 8) ? 8'hA5 : 8'($urandom);
      pix_bus.dc    = (i < 8) ? 1'b1 : 1'($urandom);
      wr_bus.ready  = 1'(i % 2);
      @(negedge clk);
      check("pass_valid", wr_bus.valid, pix_bus.valid);
      check("pass_data", wr_bus.data, pix_bus.data);
      check("pass_dc", wr_bus.dc, pix_bus.dc);
      check("pass_ready", pix_bus.ready, wr_bus.ready);
      check("pass_init_done", init_done, 1);
    end

    @(posedge clk);
    #1;
    reinit = 1'b1;
    pix_bus.valid = 1'b1;
    pix_bus.data = 8'h3C;
    pix_bus.dc = 1'b0;
    wr_bus.ready = 1'b1;
    c = cyc;
    @(negedge clk);
    check("reinit_pix_ready", pix_bus.ready, 1);
    check("reinit_wr_valid", wr_bus.valid, 1);
    check("reinit_wr_data", wr_bus.data, 8'h3C);
    run_init(c + 1, 2, -1);

    for (int r = 0; r < 3; r++) begin
      gen_rom(r != 2);
      do_reset(base);
      run_init(base, 1, -1);
    end

    // Reset while a byte is being offered
    set_directed();
    do_reset(base);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      pix_bus.valid = 1'b0;
      if (wr_bus.valid && rom_addr == 6'd2) begin
        found = 1;
        break;
      end
      wr_bus.ready = 1'b1;
    end
    check("send_reached", found, 1);
    wr_bus.ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("rst_in_send");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    run_init(base, 0, -1);

    // Reset in the middle of the programmed delay
    do_reset(base);
    found = 0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      wr_bus.ready = 1'b1;
      if (rom_addr == 6'd1 && !wr_bus.valid) cnt++;
      else cnt = 0;
      if (cnt == 4) begin
        found = 1;
        break;
      end
    end
    check("delay_reached", found, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_in_delay");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    run_init(base, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
